lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/core_pkg.sv | 39 +++
 rtl/lsu_align.sv | 57 +++++
 rtl/lsu.sv | 132 +++++++++++++
 tb/tb_lsu.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the load/store unit: FSM states, fault causes,
// func_3 encodings and the decode helpers used at instruction acceptance.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10,
    DONE = 2'b11
  } lsu_state_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_ILLEGAL  = 2'b10,
    EXC_TIMEOUT  = 2'b11
  } exc_cause_e;

  localparam int         FUNC3_W = 3;
  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;

  localparam int TIMEOUT_DEFAULT = 16;

  // Unsigned widths only exist for loads, so a store with func_3[2] set is illegal.
  function automatic logic func3_illegal(input logic [FUNC3_W-1:0] f3, input logic st);
    logic bad;
    bad = !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    return bad || (st && f3[2]);
  endfunction

  function automatic logic addr_misaligned(input logic [FUNC3_W-1:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and replicated write data, plus load
// lane extraction with sign or zero extension.
module lsu_align
  import core_pkg::*;
(
  input  logic [FUNC3_W-1:0] func_3,
  input  logic [1:0]         offset,
  input  logic [31:0]        store_data,
  input  logic [31:0]        rdata,
  output logic [3:0]         be,
  output logic [31:0]        wdata,
  output logic [31:0]        load_result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    be          = 4'b1111;
    wdata       = store_data;
    load_result = rdata;
    byte_lane   = rdata[7:0];
    half_lane   = offset[1] ? rdata[31:16] : rdata[15:0];

    case (offset)
      2'b00:   byte_lane = rdata[7:0];
      2'b01:   byte_lane = rdata[15:8];
      2'b10:   byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase

    case (func_3[1:0])
      2'b00: begin
        be    = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be    = offset[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase

    case (func_3)
      F3_B:    load_result = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    load_result = {{16{half_lane[15]}}, half_lane};
      F3_BU:   load_result = {24'h0, byte_lane};
      F3_HU:   load_result = {16'h0, half_lane};
      F3_W:    load_result = rdata;
      default: load_result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one access from the core, runs it on a req/gnt +
// rvalid memory bus, and reports decode faults or a bus timeout.
module lsu
  import core_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic               is_store,
  input  logic [FUNC3_W-1:0] func_3,
  input  logic [31:0]        addr,
  input  logic [31:0]        store_data,
  output logic               stall,
  output logic               done,
  output logic [31:0]        load_data,
  output logic               exc,
  output logic [1:0]         exc_cause,
  output logic               mem_req,
  output logic               mem_we,
  output logic [31:0]        mem_addr,
  output logic [3:0]         mem_be,
  output logic [31:0]        mem_wdata,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [31:0]        mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  lsu_state_e         state;
  logic [31:0]        addr_q;
  logic [31:0]        data_q;
  logic [FUNC3_W-1:0] func3_q;
  logic               store_q;
  logic               timed_out;
  logic [CNT_W-1:0]   cnt;

  logic        illegal;
  logic        misaligned;
  logic        accept;
  logic        fault;
  logic        last_cycle;
  logic [31:0] load_fmt;

  assign illegal    = func3_illegal(func_3, is_store);
  assign misaligned = addr_misaligned(func_3, addr[1:0]);
  assign accept     = (state == IDLE) && valid_i && !illegal && !misaligned;
  assign fault      = (state == IDLE) && valid_i && (illegal || misaligned);
  assign last_cycle = (cnt == CNT_W'(TIMEOUT - 1));

  assign stall    = accept || (state == REQ) || (state == RESP);
  assign done     = (state == DONE);
  assign exc      = fault || (done && timed_out);
  assign mem_req  = (state == REQ);
  assign mem_we   = (state == REQ) && store_q;
  assign mem_addr = {addr_q[31:2], 2'b00};

  // Decode faults win on illegal encoding; the timeout cause rides on the done pulse.
  always_comb begin
    exc_cause = EXC_NONE;
    if (fault)
      exc_cause = illegal ? EXC_ILLEGAL : EXC_MISALIGN;
    else if (done && timed_out)
      exc_cause = EXC_TIMEOUT;
  end

  lsu_align u_align (
    .func_3      (func3_q),
    .offset      (addr_q[1:0]),
    .store_data  (data_q),
    .rdata       (mem_rdata),
    .be          (mem_be),
    .wdata       (mem_wdata),
    .load_result (load_fmt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      func3_q   <= '0;
      store_q   <= 1'b0;
      timed_out <= 1'b0;
      cnt       <= '0;
      load_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          timed_out <= 1'b0;
          if (accept) begin
            addr_q  <= addr;
            data_q  <= store_data;
            func3_q <= func_3;
            store_q <= is_store;
            cnt     <= '0;
            state   <= REQ;
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (mem_gnt) begin
            state <= store_q ? DONE : RESP;
          end else if (last_cycle) begin
            state     <= DONE;
            timed_out <= 1'b1;
            load_data <= '0;
          end
        end
        RESP: begin
          cnt <= cnt + 1'b1;
          if (mem_rvalid) begin
            load_data <= load_fmt;
            state     <= DONE;
          end else if (last_cycle) begin
            state     <= DONE;
            timed_out <= 1'b1;
            load_data <= '0;
          end
        end
        DONE: begin
          timed_out <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a vector table of single accesses with immediate
// bus responses, plus hand-built sequences for wait states, timeout and reset.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        is_store;
  logic [2:0]  func_3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        exc;
  logic [1:0]  exc_cause;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld;
    logic        exc;
    logic [1:0]  cause;
  } vec_t;

  vec_t vecs[15];

  lsu #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .is_store   (is_store),
    .func_3     (func_3),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .done       (done),
    .load_data  (load_data),
    .exc        (exc),
    .exc_cause  (exc_cause),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One access with gnt and rvalid returned at the earliest opportunity.
  task automatic apply_stimulus(input vec_t v);
    next_cycle();
    valid_i    = 1'b1;
    is_store   = v.st;
    func_3     = v.f3;
    addr       = v.addr;
    store_data = v.sdata;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    if (v.exc) begin
      check_output("fault_exc", exc, 1);
      check_output("fault_cause", exc_cause, v.cause);
      check_output("fault_stall", stall, 0);
      check_output("fault_req", mem_req, 0);
      check_output("fault_done", done, 0);
      next_cycle();
      valid_i = 1'b0;
      @(negedge clk);
      check_output("fault_idle_req", mem_req, 0);
      check_output("fault_exc_pulse", exc, 0);
      return;
    end
    check_output("accept_stall", stall, 1);
    check_output("accept_exc", exc, 0);
    next_cycle();
    mem_gnt = 1'b1;
    @(negedge clk);
    check_output("req", mem_req, 1);
    check_output("req_we", mem_we, v.st);
    check_output("req_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
    check_output("req_be", mem_be, v.be);
    if (v.st) check_output("req_wdata", mem_wdata, v.wdata);
    check_output("req_stall", stall, 1);
    next_cycle();
    mem_gnt = 1'b0;
    if (!v.st) begin
      mem_rvalid = 1'b1;
      mem_rdata  = v.rdata;
      @(negedge clk);
      check_output("resp_stall", stall, 1);
      check_output("resp_req", mem_req, 0);
      next_cycle();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end
    @(negedge clk);
    check_output("done", done, 1);
    check_output("done_stall", stall, 0);
    check_output("done_exc", exc, 0);
    if (!v.st) check_output("load_data", load_data, v.ld);
    next_cycle();
    valid_i = 1'b0;
    @(negedge clk);
    check_output("done_pulse", done, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int done_cyc;

    //               st    f3      addr          sdata         rdata         be       wdata         ld            exc   cause
    vecs[0]  = '{1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0,        4'b1000, 32'hABAB_ABAB, 32'h0,        1'b0, 2'b00};
    vecs[1]  = '{1'b1, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 32'h0,        4'b1100, 32'hBEEF_BEEF, 32'h0,        1'b0, 2'b00};
    vecs[2]  = '{1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0,        4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0, 2'b00};
    vecs[3]  = '{1'b0, 3'b000, 32'h0000_2002, 32'h0,        32'h0080_0000, 4'b0100, 32'h0,         32'hFFFF_FF80, 1'b0, 2'b00};
    vecs[4]  = '{1'b0, 3'b100, 32'h0000_2002, 32'h0,        32'h0080_0000, 4'b0100, 32'h0,         32'h0000_0080, 1'b0, 2'b00};
    vecs[5]  = '{1'b0, 3'b001, 32'h0000_2000, 32'h0,        32'h1234_8765, 4'b0011, 32'h0,         32'hFFFF_8765, 1'b0, 2'b00};
    vecs[6]  = '{1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'h8765_1234, 4'b1100, 32'h0,         32'h0000_8765, 1'b0, 2'b00};
    vecs[7]  = '{1'b0, 3'b010, 32'h0000_2004, 32'h0,        32'hCAFE_F00D, 4'b1111, 32'h0,         32'hCAFE_F00D, 1'b0, 2'b00};
    vecs[8]  = '{1'b0, 3'b000, 32'h0000_2001, 32'h0,        32'h0000_7F00, 4'b0010, 32'h0,         32'h0000_007F, 1'b0, 2'b00};
    vecs[9]  = '{1'b0, 3'b010, 32'h0000_2001, 32'h0,        32'h0,         4'b0000, 32'h0,         32'h0,        1'b1, 2'b01};
    vecs[10] = '{1'b1, 3'b110, 32'h0000_2000, 32'h0,        32'h0,         4'b0000, 32'h0,         32'h0,        1'b1, 2'b10};
    vecs[11] = '{1'b0, 3'b001, 32'h0000_2003, 32'h0,        32'h0,         4'b0000, 32'h0,         32'h0,        1'b1, 2'b01};
    vecs[12] = '{1'b1, 3'b100, 32'h0000_2000, 32'h0,        32'h0,         4'b0000, 32'h0,         32'h0,        1'b1, 2'b10};
    vecs[13] = '{1'b0, 3'b011, 32'h0000_2001, 32'h0,        32'h0,         4'b0000, 32'h0,         32'h0,        1'b1, 2'b10};
    vecs[14] = '{1'b1, 3'b001, 32'h0000_1001, 32'h0,        32'h0,         4'b0000, 32'h0,         32'h0,        1'b1, 2'b01};

    rst        = 1'b1;
    valid_i    = 1'b0;
    is_store   = 1'b0;
    func_3     = 3'b000;
    addr       = 32'h0;
    store_data = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_output("rst_stall", stall, 0);
    check_output("rst_done", done, 0);
    check_output("rst_exc", exc, 0);
    check_output("rst_cause", exc_cause, 0);
    check_output("rst_req", mem_req, 0);
    check_output("rst_we", mem_we, 0);
    check_output("rst_load_data", load_data, 0);

    for (int i = 0; i < 15; i++) apply_stimulus(vecs[i]);

    // LH with two gnt wait cycles and three rvalid wait cycles; a stray rvalid
    // during REQ must not be taken as the response.
    $display("[TB] delayed LH");
    next_cycle();
    valid_i = 1'b1; is_store = 1'b0; func_3 = 3'b001; addr = 32'h0000_2002;
    @(negedge clk);
    check_output("dly_accept_stall", stall, 1);
    done_cyc = 0;
    for (int cyc = 2; cyc <= 20; cyc++) begin
      next_cycle();
      mem_gnt    = (cyc == 4);
      mem_rvalid = (cyc == 2) || (cyc == 8);
      mem_rdata  = (cyc == 2) ? 32'hFFFF_FFFF : 32'h8001_0000;
      @(negedge clk);
      if (done) begin
        done_cyc = cyc;
        break;
      end
      check_output("dly_stall", stall, 1);
    end
    check_output("dly_done_cycle", done_cyc, 9);
    check_output("dly_load_data", load_data, 32'hFFFF_8001);
    next_cycle();
    valid_i = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    // LW whose grant never arrives: 16 cycles in REQ, then a timeout fault on done.
    $display("[TB] bus timeout");
    next_cycle();
    valid_i = 1'b1; is_store = 1'b0; func_3 = 3'b010; addr = 32'h0000_3000;
    @(negedge clk);
    done_cyc = 0;
    for (int cyc = 2; cyc <= 40; cyc++) begin
      next_cycle();
      @(negedge clk);
      if (done) begin
        done_cyc = cyc;
        break;
      end
      check_output("to_req", mem_req, 1);
    end
    check_output("to_done_cycle", done_cyc, 18);
    check_output("to_exc", exc, 1);
    check_output("to_cause", exc_cause, 2'b11);
    check_output("to_load_data", load_data, 0);
    next_cycle();
    valid_i = 1'b0;
    @(negedge clk);
    check_output("to_exc_pulse", exc, 0);

    // Reset while waiting in RESP, then a late rvalid: the access is dropped.
    $display("[TB] reset in RESP");
    apply_stimulus(vecs[3]);
    next_cycle();
    valid_i = 1'b1; is_store = 1'b0; func_3 = 3'b010; addr = 32'h0000_4000;
    next_cycle();
    mem_gnt = 1'b1;
    @(negedge clk);
    check_output("rr_req", mem_req, 1);
    next_cycle();
    mem_gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_output("rr_resp_stall", stall, 1);
    next_cycle();
    rst = 1'b0; valid_i = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    check_output("rr_req_drop", mem_req, 0);
    check_output("rr_stall", stall, 0);
    check_output("rr_done", done, 0);
    check_output("rr_load_data", load_data, 0);
    next_cycle();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    check_output("rr_late_done", done, 0);
    check_output("rr_late_load_data", load_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
